// File: rtl/column_renderer.sv
// column_renderer: double-buffered per-column wall table rendering ceiling/wall/floor pixels.
// Ports: clk_in/rst_n_in clock and async active-low reset; sx_in/sy_in/hsync_in/vsync_in/de_in
// from the timing generator; col_* valid/ready write channel from the raycaster; frame_req_out
// and frame_drop_out frame pulses; r/g/b_out, hsync_out, vsync_out, de_out delayed two cycles.
module column_renderer #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int HEIGHT_W = 9,
  parameter int COLOR_W  = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [9:0]          sx_in,
  input  logic [9:0]          sy_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                de_in,
  input  logic                col_valid_in,
  output logic                col_ready_out,
  input  logic [9:0]          col_x_in,
  input  logic [HEIGHT_W-1:0] col_height_in,
  input  logic [1:0]          col_shade_in,
  input  logic                col_last_in,
  output logic                frame_req_out,
  output logic                frame_drop_out,
  output logic [COLOR_W-1:0]  r_out,
  output logic [COLOR_W-1:0]  g_out,
  output logic [COLOR_W-1:0]  b_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                de_out
);
  localparam int AW   = $clog2(H_RES);
  localparam int HALF = V_RES / 2;
  localparam logic [COLOR_W-1:0] CEIL_R = COLOR_W'(1), CEIL_G = COLOR_W'(2), CEIL_B = COLOR_W'(6);
  localparam logic [COLOR_W-1:0] FLR_C  = COLOR_W'(3);
  localparam logic [COLOR_W-1:0] WALL_R = COLOR_W'(15), WALL_G = COLOR_W'(12), WALL_B = COLOR_W'(8);

  typedef enum logic {FILL, DONE} state_e;
  state_e state_q, state_d;

  logic                bank_q, front_valid_q, boot_q, boot_pulse_q;
  logic [9:0]          sy1_q;
  logic                hs1_q, vs1_q, de1_q;
  logic                hs2_q, vs2_q, de2_q;
  logic [HEIGHT_W+1:0] mem [2][H_RES];
  logic [HEIGHT_W+1:0] rd_q;
  logic [COLOR_W-1:0]  r_q, g_q, b_q, r_d, g_d, b_d;
  logic                fire, vstart, swap;
  logic [9:0]          half, top, bot;
  logic                big, ceil, flr;
  logic [1:0]          shade;

  assign fire   = col_valid_in && col_ready_out;
  // vs2_q is vs1_q one cycle later, so this marks the cycle after vsync_in falls
  assign vstart = vs2_q && !vs1_q;

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state_q <= FILL;
    else state_q <= state_d;

  always_comb
    state_d = (state_q == FILL) ? ((fire && col_last_in) ? DONE : FILL) : (vstart ? FILL : DONE);

  always_comb begin
    col_ready_out  = boot_q && (state_q == FILL);
    swap           = (state_q == DONE) && vstart;
    frame_req_out  = boot_pulse_q || swap;
    frame_drop_out = (state_q == FILL) && vstart;
  end

  // boot_pulse_q yields the single frame request on the first edge after reset release
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      bank_q        <= 1'b0;
      front_valid_q <= 1'b0;
      boot_q        <= 1'b0;
      boot_pulse_q  <= 1'b0;
    end else begin
      boot_q       <= 1'b1;
      boot_pulse_q <= !boot_q;
      if (swap) begin
        bank_q        <= !bank_q;
        front_valid_q <= 1'b1;
      end
    end

  // Table RAM is never cleared; bank_q selects the front (read) bank, the other is filled
  always_ff @(posedge clk_in) begin
    if (fire && col_x_in < 10'(H_RES)) mem[!bank_q][AW'(col_x_in)] <= {col_height_in, col_shade_in};
    rd_q <= mem[bank_q][(sx_in < 10'(H_RES)) ? AW'(sx_in) : '0];
  end

  always_comb begin
    shade = rd_q[1:0];
    half  = 10'(rd_q[HEIGHT_W+1:2] >> 1);
    big   = half >= 10'(HALF);
    top   = big ? 10'd0 : 10'(HALF) - half;
    bot   = big ? 10'(V_RES) : 10'(HALF) + half;
    ceil  = front_valid_q ? (sy1_q < top) : (sy1_q < 10'(HALF));
    flr   = front_valid_q ? (sy1_q >= bot) : 1'b1;
    r_d   = !de1_q ? '0 : ceil ? CEIL_R : flr ? FLR_C : WALL_R >> shade;
    g_d   = !de1_q ? '0 : ceil ? CEIL_G : flr ? FLR_C : WALL_G >> shade;
    b_d   = !de1_q ? '0 : ceil ? CEIL_B : flr ? FLR_C : WALL_B >> shade;
  end

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      sy1_q <= '0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      de1_q <= 1'b0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
      de2_q <= 1'b0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      sy1_q <= sy_in;
      hs1_q <= hsync_in;
      vs1_q <= vsync_in;
      de1_q <= de_in;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      de2_q <= de1_q;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
    end

  assign r_out     = r_q;
  assign g_out     = g_q;
  assign b_out     = b_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign de_out    = de2_q;
endmodule

// File: tb/tb_column_renderer.sv
// tb_column_renderer: directed self-checking bench for column_renderer
module tb_column_renderer;
  logic       clk = 0, rst_n = 0;
  logic [9:0] sx = 0, sy = 0, cx = 0;
  logic       hs = 1, vs = 1, de = 0, cv = 0, cl = 0;
  logic [8:0] ch = 0;
  logic [1:0] cs = 0;
  logic       ready, req, drop, hs_o, vs_o, de_o;
  logic [3:0] r, g, b;
  int         n_chk = 0, n_fail = 0;

  column_renderer dut (
    .clk_in(clk), .rst_n_in(rst_n), .sx_in(sx), .sy_in(sy), .hsync_in(hs), .vsync_in(vs),
    .de_in(de), .col_valid_in(cv), .col_ready_out(ready), .col_x_in(cx), .col_height_in(ch),
    .col_shade_in(cs), .col_last_in(cl), .frame_req_out(req), .frame_drop_out(drop),
    .r_out(r), .g_out(g), .b_out(b), .hsync_out(hs_o), .vsync_out(vs_o), .de_out(de_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic [11:0] rgb, input string tag);
    sx = 10'(x);
    sy = 10'(y);
    de = 1;
    step(2);
    chk(tag, 32'({de_o, r, g, b}), 32'({1'b1, rgb}));
    de = 0;
  endtask

  task automatic write_col(input int x, input int h, input int s, input bit last);
    cv = 1;
    cx = 10'(x);
    ch = 9'(h);
    cs = 2'(s);
    cl = last;
    if (ready !== 1'b1) chk("wr_ready", 32'(ready), 1);
    step();
    cv = 0;
    cl = 0;
  endtask

  task automatic vsync(input bit exp_req, input bit exp_drop, input string tag);
    vs = 0;
    step();
    chk({tag, "_req"}, 32'(req), 32'(exp_req));
    chk({tag, "_drop"}, 32'(drop), 32'(exp_drop));
    step();
    chk({tag, "_once"}, 32'({req, drop}), 0);
    vs = 1;
    step(2);
  endtask

  initial begin
    step(2);
    chk("rst_out", 32'({de_o, hs_o, vs_o, r, g, b}), 32'({3'b011, 12'h000}));
    chk("rst_ctl", 32'({ready, req, drop}), 0);
    rst_n = 1;
    step();
    chk("boot_req", 32'(req), 1);
    chk("boot_ready", 32'(ready), 1);
    step();
    chk("boot_req_once", 32'(req), 0);

    de = 1;
    hs = 0;
    step();
    chk("dly1", 32'({de_o, hs_o}), 32'(2'b01));
    de = 0;
    hs = 1;
    step();
    chk("dly2", 32'({de_o, hs_o}), 32'(2'b10));
    step();
    chk("dly3", 32'({de_o, hs_o}), 32'(2'b01));

    pix(10, 100, 12'h126, "f0_ceil");
    pix(10, 300, 12'h333, "f0_floor");

    for (int x = 0; x < 640; x++) write_col(x, x == 5 ? 511 : 100, x == 5 ? 2 : 0, x == 639);
    chk("done_ready", 32'(ready), 0);
    vsync(1, 0, "swap1");
    chk("swap1_ready", 32'(ready), 1);
    pix(10, 189, 12'h126, "a_189");
    pix(10, 190, 12'hFC8, "a_190");
    pix(10, 289, 12'hFC8, "a_289");
    pix(10, 290, 12'h333, "a_290");
    pix(5, 0, 12'h332, "a_x5_top");
    pix(5, 479, 12'h332, "a_x5_bot");
    pix(4, 100, 12'h126, "a_x4");
    pix(6, 200, 12'hFC8, "a_x6");

    for (int x = 0; x <= 300; x++) write_col(x, 300, 1, 0);
    vsync(0, 1, "drop");
    chk("drop_ready", 32'(ready), 1);
    pix(10, 189, 12'h126, "rep_189");
    pix(10, 200, 12'hFC8, "rep_200");
    for (int x = 301; x < 640; x++) begin
      if (x == 400) write_col(700, 0, 3, 0);
      write_col(x, 300, 1, x == 639);
    end
    cv = 1;
    cx = 20;
    ch = 0;
    cs = 3;
    cl = 1;
    step(3);
    chk("hold_ready", 32'(ready), 0);
    cv = 0;
    cl = 0;
    vsync(1, 0, "swap2");
    pix(10, 89, 12'h126, "b_89");
    pix(10, 90, 12'h764, "b_90");
    pix(10, 389, 12'h764, "b_389");
    pix(10, 390, 12'h333, "b_390");
    pix(20, 200, 12'h764, "b_x20_hold");
    pix(60, 200, 12'h764, "b_x60");
    pix(188, 200, 12'h764, "b_x188");
    pix(5, 0, 12'h126, "b_x5");

    sx = 10;
    sy = 200;
    de = 1;
    hs = 0;
    step(2);
    chk("pre_rst", 32'({de_o, hs_o, r, g, b}), 32'({2'b10, 12'h764}));
    #2 rst_n = 0;
    #1;
    chk("async_rst_out", 32'({de_o, hs_o, vs_o, r, g, b}), 32'({3'b011, 12'h000}));
    chk("async_rst_ctl", 32'({ready, req, drop}), 0);
    de = 0;
    hs = 1;
    @(posedge clk);
    #1 rst_n = 1;
    step();
    chk("reboot_req", 32'(req), 1);
    pix(10, 200, 12'h126, "rst_ceil");
    pix(10, 300, 12'h333, "rst_floor");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
